ysyx_24100013_inst_queue: RTL

Instruction queue between the instruction fetch stage and the decode stage of the ysyx_24100013 core. Buffers up to DEPTH fetched {pc, inst} pairs in FIFO order with valid/ready handshakes on both sides. Decouples the fetch stage's `pmem_read` timing from decode stalls. Supports a single-cycle flush for branch/jump redirects.

---
 rtl/ysyx_24100013_inst_queue.sv | 60 ++++++
 1 files changed

// File: rtl/ysyx_24100013_inst_queue.sv
// ysyx_24100013_inst_queue: fetch-to-decode FIFO of {pc, inst} pairs with flush
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready/in_pc/in_inst  fetch-side handshake and payload
//   out_valid/out_ready/out_pc/out_inst  decode-side handshake and head payload
//   flush                            drop all entries at the next edge
//   count                            number of valid entries, 0..DEPTH
module ysyx_24100013_inst_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_inst,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem_pc   [DEPTH];
  logic [XLEN-1:0] mem_inst [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, empty, full;
  assign empty     = count == '0;
  assign full      = count == (AW+1)'(DEPTH);
  // flush gates both handshakes so no push or pop can coincide with it
  assign in_ready  = ~full & ~flush;
  assign out_valid = ~empty & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign out_inst  = empty ? '0 : mem_inst[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_inst[wr_ptr] <= in_inst;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count  <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
    end
  end
endmodule
